// File: rtl/data_mem_bus_responder.sv
// Responder end of the data-memory bus: byte/half/word loads and stores on an internal word RAM,
// with a fixed number of wait states and a registered single-cycle bus_ready/bus_error response.
module data_mem_bus_responder #(
    parameter int              ADDR_WIDTH  = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [31:0]     BASE_ADDR   = 32'h1001_0000,
    parameter int              WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [31:0]           bus_wdata,
    input  logic                  bus_wren,
    input  logic                  bus_rden,
    input  logic [1:0]            bus_size,
    input  logic                  bus_unsigned,
    output logic [31:0]           bus_rdata,
    output logic                  bus_ready,
    output logic                  bus_error,
    output logic [1:0]            dbg_state
);

    // Handshake: a request (bus_wren|bus_rden) is taken only when the FSM is IDLE at a rising edge;
    // exactly one bus_ready pulse follows, and bus_error qualifies that pulse.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int                  IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]          WS_INIT     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] RANGE_BYTES = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

    state_t                  state, state_next;
    logic [3:0]              cnt, cnt_next;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [31:0]             cap_wdata;
    logic [1:0]              cap_size;
    logic                    cap_uns;
    logic                    cap_wr;
    logic                    cap_rd;
    logic                    req;
    logic                    capture;

    logic [ADDR_WIDTH-1:0]   acc_off;
    logic [IDX_W-1:0]        acc_idx;
    logic [1:0]              lane;
    logic                    err;
    logic [31:0]             rd_word;
    logic [31:0]             shifted;
    logic [31:0]             load_data;
    logic [3:0]              be;
    logic [31:0]             wr_data;
    logic                    do_write;

    logic [31:0]             mem [DEPTH_WORDS];

    assign dbg_state = state;
    assign req       = bus_wren | bus_rden;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    capture    = 1'b1;
                    cnt_next   = WS_INIT;
                    state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_next = S_RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // In IDLE the live address feeds the RAM read so a zero-wait access has its word at RESP entry.
    always_comb begin
        acc_off = ((state == S_IDLE) ? bus_addr : cap_addr) - BASE;
        acc_idx = acc_off[IDX_W+1:2];
        lane    = cap_addr[1:0];
        err     = (cap_wr & cap_rd)
                | (cap_size == 2'b11)
                | ((cap_size == 2'b01) & cap_addr[0])
                | ((cap_size == 2'b10) & (cap_addr[1:0] != 2'b00))
                | ({1'b0, acc_off} >= RANGE_BYTES);
    end

    always_comb begin
        shifted = rd_word >> {lane, 3'b000};
        case (cap_size)
            2'b00:   load_data = cap_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = cap_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = rd_word;
        endcase
        case (cap_size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        case (cap_size)
            2'b00:   wr_data = {4{cap_wdata[7:0]}};
            2'b01:   wr_data = {2{cap_wdata[15:0]}};
            default: wr_data = cap_wdata;
        endcase
        do_write = (state == S_RESP) & cap_wr & ~err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_size  <= '0;
            cap_uns   <= 1'b0;
            cap_wr    <= 1'b0;
            cap_rd    <= 1'b0;
            bus_ready <= 1'b0;
            bus_error <= 1'b0;
            bus_rdata <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bus_ready <= (state == S_RESP);
            if (capture) begin
                cap_addr  <= bus_addr;
                cap_wdata <= bus_wdata;
                cap_size  <= bus_size;
                cap_uns   <= bus_unsigned;
                cap_wr    <= bus_wren;
                cap_rd    <= bus_rden;
            end
            if (state == S_RESP) begin
                bus_error <= err;
                bus_rdata <= (err | ~cap_rd) ? 32'd0 : load_data;
            end
        end
    end

    // RAM is not reset; a reset forces IDLE asynchronously, which also drops any pending write.
    always_ff @(posedge clk) begin
        rd_word <= mem[acc_idx];
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_bus_responder.sv
// Directed bench for data_mem_bus_responder: three instances (0, 1 and 3 wait states) share one bus.
module tb_data_mem_bus_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_wren = 1'b0;
    logic        bus_rden = 1'b0;
    logic [1:0]  bus_size = 2'b10;
    logic        bus_unsigned = 1'b0;

    logic [2:0]  rdy;
    logic [2:0]  errv;
    logic [31:0] rdat [3];
    logic [1:0]  dbg [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_bus_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wren(bus_wren),
        .bus_rden(bus_rden), .bus_size(bus_size), .bus_unsigned(bus_unsigned),
        .bus_rdata(rdat[0]), .bus_ready(rdy[0]), .bus_error(errv[0]), .dbg_state(dbg[0]));

    data_mem_bus_responder #(.WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wren(bus_wren),
        .bus_rden(bus_rden), .bus_size(bus_size), .bus_unsigned(bus_unsigned),
        .bus_rdata(rdat[1]), .bus_ready(rdy[1]), .bus_error(errv[1]), .dbg_state(dbg[1]));

    data_mem_bus_responder #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wren(bus_wren),
        .bus_rden(bus_rden), .bus_size(bus_size), .bus_unsigned(bus_unsigned),
        .bus_rdata(rdat[2]), .bus_ready(rdy[2]), .bus_error(errv[2]), .dbg_state(dbg[2]));

    // One-cycle request pulse, then wait (bounded) for the selected instance's ready.
    // lat = rising edges from the request edge to the edge that raised bus_ready.
    task automatic xfer(input int which, input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        output int lat, output logic [31:0] rdata, output logic err);
        lat = -1;
        rdata = 'x;
        err = 1'bx;
        @(negedge clk);
        bus_wren = wr; bus_rden = rd; bus_addr = addr; bus_wdata = wdata;
        bus_size = size; bus_unsigned = uns;
        @(negedge clk);
        bus_wren = 1'b0; bus_rden = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (rdy[which]) begin
                lat = k - 1;
                rdata = rdat[which];
                err = errv[which];
                break;
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({rdy[d], errv[d], rdat[d], dbg[d]} !== 36'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got rdy=%b err=%b rdata=%h st=%0d required all 0",
                         d, rdy[d], errv[d], rdat[d], dbg[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er;
        xfer(1, 1, 0, BASE + 32'h10, 32'hDEADBEEF, 2'b10, 0, lat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL sw_word got lat=%0d err=%b rdata=%h required lat=2 err=0 rdata=0", lat, er, rd);
        end
        xfer(1, 0, 1, BASE + 32'h10, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL lw_word got %h err=%b lat=%0d required deadbeef err=0 lat=2", rd, er, lat);
        end
    endtask

    task automatic test_subword();
        int lat; logic [31:0] rd; logic er;
        xfer(1, 1, 0, BASE + 32'h10, 32'h11223344, 2'b10, 0, lat, rd, er);
        xfer(1, 1, 0, BASE + 32'h12, 32'h000000AB, 2'b00, 0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL sb_resp got err=%b lat=%0d required err=0 lat=2", er, lat);
        end
        xfer(1, 0, 1, BASE + 32'h10, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (rd !== 32'h11AB3344) begin
            errors++;
            $display("FAIL sb_merge got %h required 11ab3344", rd);
        end
        xfer(1, 0, 1, BASE + 32'h12, 0, 2'b00, 0, lat, rd, er);
        checks++;
        if (rd !== 32'hFFFFFFAB) begin
            errors++;
            $display("FAIL lb_sext got %h required ffffffab", rd);
        end
        xfer(1, 0, 1, BASE + 32'h12, 0, 2'b00, 1, lat, rd, er);
        checks++;
        if (rd !== 32'h000000AB) begin
            errors++;
            $display("FAIL lbu_zext got %h required 000000ab", rd);
        end
        xfer(1, 0, 1, BASE + 32'h12, 0, 2'b01, 0, lat, rd, er);
        checks++;
        if (rd !== 32'h000011AB) begin
            errors++;
            $display("FAIL lh_upper got %h required 000011ab", rd);
        end
        xfer(1, 0, 1, BASE + 32'h10, 0, 2'b01, 0, lat, rd, er);
        checks++;
        if (rd !== 32'h00003344) begin
            errors++;
            $display("FAIL lh_lower got %h required 00003344", rd);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er;
        xfer(1, 1, 0, BASE + 32'h0, 32'hCAFEF00D, 2'b10, 0, lat, rd, er);
        xfer(1, 0, 1, BASE + 32'h2, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin
            errors++;
            $display("FAIL lw_misaligned got err=%b rdata=%h lat=%0d required err=1 rdata=0 lat=2", er, rd, lat);
        end
        xfer(1, 1, 0, BASE + 32'h1, 32'h00005555, 2'b01, 0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL sh_misaligned got err=%b rdata=%h required err=1 rdata=0", er, rd);
        end
        xfer(1, 0, 1, BASE + 32'h0, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_nowrite got %h err=%b required cafef00d err=0", rd, er);
        end
        xfer(1, 0, 1, BASE + 32'h0, 0, 2'b11, 0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL size_illegal got err=%b rdata=%h required err=1 rdata=0", er, rd);
        end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic er;
        xfer(1, 0, 1, BASE + DEPTH * 4, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL range_top got err=%b rdata=%h required err=1 rdata=0", er, rd);
        end
        xfer(1, 0, 1, BASE + DEPTH * 4 - 4, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL range_last got err=%b required err=0", er);
        end
        xfer(1, 0, 1, BASE - 32'd4, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL range_below got err=%b rdata=%h required err=1 rdata=0", er, rd);
        end
        xfer(1, 1, 0, BASE + 32'h20, 32'h01234567, 2'b10, 0, lat, rd, er);
        xfer(1, 1, 1, BASE + 32'h20, 32'h89ABCDEF, 2'b10, 0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL wr_and_rd got err=%b rdata=%h required err=1 rdata=0", er, rd);
        end
        xfer(1, 0, 1, BASE + 32'h20, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (rd !== 32'h01234567) begin
            errors++;
            $display("FAIL wr_and_rd_nowrite got %h required 01234567", rd);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic [31:0] rd; logic er;
        int pulses;
        xfer(0, 0, 1, BASE + 32'h10, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (lat !== 1 || rd !== 32'h11AB3344) begin
            errors++;
            $display("FAIL ws0_latency got lat=%0d rdata=%h required lat=1 rdata=11ab3344", lat, rd);
        end
        xfer(2, 0, 1, BASE + 32'h10, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (lat !== 4 || rd !== 32'h11AB3344) begin
            errors++;
            $display("FAIL ws3_latency got lat=%0d rdata=%h required lat=4 rdata=11ab3344", lat, rd);
        end
        // second pulse lands while the 3-wait instance is still in WAIT
        pulses = 0;
        @(negedge clk);
        bus_rden = 1'b1; bus_addr = BASE + 32'h10; bus_size = 2'b10;
        @(negedge clk);
        bus_rden = 1'b0;
        @(negedge clk);
        bus_rden = 1'b1;
        @(negedge clk);
        bus_rden = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (rdy[2]) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ws3_ignore_in_wait got %0d ready pulses required 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er;
        int pulses;
        xfer(1, 1, 0, BASE + 32'h30, 32'h0BADF00D, 2'b10, 0, lat, rd, er);
        xfer(1, 0, 1, BASE + 32'h30, 0, 2'b10, 0, lat, rd, er);
        @(negedge clk);
        bus_wren = 1'b1; bus_addr = BASE + 32'h30; bus_wdata = 32'h55AA55AA; bus_size = 2'b10;
        @(negedge clk);
        bus_wren = 1'b0;
        checks++;
        if (dbg[1] !== 2'd1) begin
            errors++;
            $display("FAIL mid_in_wait got state=%0d required 1", dbg[1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy[1] !== 1'b0 || errv[1] !== 1'b0 || rdat[1] !== 32'd0 || dbg[1] !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got rdy=%b err=%b rdata=%h st=%0d required all 0",
                     rdy[1], errv[1], rdat[1], dbg[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rdy != 3'b000) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL mid_reset_noready got %0d ready cycles required 0", pulses);
        end
        xfer(1, 0, 1, BASE + 32'h30, 0, 2'b10, 0, lat, rd, er);
        checks++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_store_dropped got %h err=%b required 0badf00d err=0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_misaligned();
        test_range();
        test_wait_states();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
